// File: rtl/dl_rom_pkg.sv
// dl_rom_pkg: stream index constants and the address-window lookup shared by the ROM download router.
package dl_rom_pkg;
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;
    localparam int MAX_REG = 8;
    localparam int MAX_AW  = 32;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } region_t;

    // Scans from the top so the lowest matching region is the one left standing.
    function automatic region_t region_of(
        input logic [MAX_AW-1:0]         addr,
        input logic [MAX_REG*MAX_AW-1:0] base,
        input logic [MAX_REG*5-1:0]      lg,
        input int                        nreg
    );
        region_t         r;
        logic [MAX_AW:0] lo;
        logic [MAX_AW:0] hi;
        r = '0;
        for (int i = MAX_REG - 1; i >= 0; i--) begin
            lo = {1'b0, base[i*MAX_AW +: MAX_AW]};
            hi = lo + ({{MAX_AW{1'b0}}, 1'b1} << lg[i*5 +: 5]);
            if (i < nreg && {1'b0, addr} >= lo && {1'b0, addr} < hi) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/dl_word_packer.sv
// dl_word_packer: registers routed ROM bytes into output words, pairing little-endian bytes when PACK=2.
module dl_word_packer
    import dl_rom_pkg::*;
#(
    parameter int NREG = 4,
    parameter int PACK = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                wr,
    input  logic [NREG-1:0]     sel,
    input  logic [23:0]         off,
    input  logic [7:0]          din,
    input  logic                flush,
    output logic [NREG-1:0]     we,
    output logic [23:0]         addr,
    output logic [8*PACK-1:0]   data
);
    if (PACK == 1) begin : g_byte
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                we   <= '0;
                addr <= '0;
                data <= '0;
            end else begin
                we <= (wr & ~flush) ? sel : '0;
                if (wr) begin
                    addr <= off;
                    data <= din;
                end
            end
        end
    end else begin : g_word
        logic            pv, hv;
        logic [NREG-1:0] p_sel, h_sel, in_sel;
        logic [22:0]     p_word;
        logic [23:0]     h_off, in_off;
        logic [7:0]      p_lo, h_din, in_din;
        logic            in_v, need_flush;
        // A byte displaced by a flush is parked in the hold slot and replayed next cycle.
        always_comb begin
            in_v       = hv | wr;
            in_sel     = hv ? h_sel : sel;
            in_off     = hv ? h_off : off;
            in_din     = hv ? h_din : din;
            need_flush = pv & (flush | (in_v & (in_sel != p_sel || in_off[23:1] != p_word)));
        end
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                we     <= '0;
                addr   <= '0;
                data   <= '0;
                pv     <= 1'b0;
                hv     <= 1'b0;
                p_sel  <= '0;
                p_word <= '0;
                p_lo   <= '0;
                h_sel  <= '0;
                h_off  <= '0;
                h_din  <= '0;
            end else begin
                we <= '0;
                hv <= 1'b0;
                if (need_flush) begin
                    we    <= p_sel;
                    addr  <= {1'b0, p_word};
                    data  <= {8'h00, p_lo};
                    pv    <= 1'b0;
                    hv    <= in_v;
                    h_sel <= in_sel;
                    h_off <= in_off;
                    h_din <= in_din;
                end else if (in_v & (in_off[0] | flush)) begin
                    we   <= in_sel;
                    addr <= {1'b0, in_off[23:1]};
                    data <= in_off[0] ? {in_din, pv ? p_lo : 8'h00} : {8'h00, in_din};
                    pv   <= 1'b0;
                end else if (in_v) begin
                    pv     <= 1'b1;
                    p_sel  <= in_sel;
                    p_word <= in_off[23:1];
                    p_lo   <= in_din;
                end
            end
        end
    end
endmodule

// File: rtl/dl_rom_router.sv
// dl_rom_router: steers the hps_io download stream into NREG ROM regions and captures the mod and DIP bytes.
module dl_rom_router
    import dl_rom_pkg::*;
#(
    parameter int                 NREG      = 4,
    parameter int                 AW        = 25,
    parameter int                 PACK      = 1,
    parameter logic [NREG*AW-1:0] REG_BASE  = {NREG{25'h0}},
    parameter logic [NREG*5-1:0]  REG_LOG2  = {NREG{5'd12}},
    parameter logic [7:0]         ROM_INDEX = IDX_ROM
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [AW-1:0]     ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [NREG-1:0]   rom_we,
    output logic [23:0]       rom_addr,
    output logic [8*PACK-1:0] rom_data,
    output logic [NREG-1:0]   region_full,
    output logic              dl_done,
    output logic              unmapped,
    output logic [7:0]        mod_byte,
    output logic [63:0]       dip_sw
);
    logic [MAX_REG*MAX_AW-1:0] base_pad;
    logic [MAX_REG*5-1:0]      lg_pad;
    region_t                   rr;
    logic [23:0]               off;
    logic [NREG-1:0]           hit_oh;
    logic [24:0]               cnt [NREG];
    logic rom_idx, acc, hit_wr, rise, rom_rise, fall;
    logic dl_q, low_seen, armed, fall_q;

    always_comb begin
        base_pad = '0;
        lg_pad   = '0;
        for (int i = 0; i < NREG; i++) begin
            base_pad[i*MAX_AW +: MAX_AW] = MAX_AW'(REG_BASE[i*AW +: AW]);
            lg_pad[i*5 +: 5]             = REG_LOG2[i*5 +: 5];
        end
        rr       = region_of(MAX_AW'(ioctl_addr), base_pad, lg_pad, NREG);
        off      = 24'(MAX_AW'(ioctl_addr) - base_pad[rr.idx*MAX_AW +: MAX_AW]);
        rom_idx  = ioctl_index == ROM_INDEX;
        acc      = ioctl_wr & ioctl_download & rom_idx;
        hit_wr   = acc & rr.hit;
        hit_oh   = hit_wr ? (NREG'(1) << rr.idx) : '0;
        // low_seen keeps a download that was already running across reset from looking like a fresh start.
        rise     = ioctl_download & ~dl_q & low_seen;
        rom_rise = rise & rom_idx;
        fall     = dl_q & ~ioctl_download & rom_idx;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q        <= 1'b0;
            low_seen    <= 1'b0;
            armed       <= 1'b0;
            fall_q      <= 1'b0;
            dl_done     <= 1'b0;
            region_full <= '0;
            unmapped    <= 1'b0;
            mod_byte    <= '0;
            dip_sw      <= '0;
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            dl_q     <= ioctl_download;
            low_seen <= low_seen | ~ioctl_download;
            armed    <= rom_rise | (armed & ~fall);
            fall_q   <= fall & armed;
            dl_done  <= fall_q;
            if (fall_q)
                for (int i = 0; i < NREG; i++) region_full[i] <= cnt[i] == (25'd1 << REG_LOG2[i*5 +: 5]);
            if (rom_rise) region_full <= '0;
            unmapped <= ~rom_rise & (unmapped | (acc & ~rr.hit));
            for (int i = 0; i < NREG; i++)
                cnt[i] <= rom_rise ? '0 : (hit_oh[i] && ~&cnt[i]) ? cnt[i] + 25'd1 : cnt[i];
            if (ioctl_wr & ioctl_download & (ioctl_index == IDX_MOD)) mod_byte <= ioctl_dout;
            if (ioctl_wr & ioctl_download & (ioctl_index == IDX_DIP) & (ioctl_addr[AW-1:3] == '0))
                dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    dl_word_packer #(.NREG(NREG), .PACK(PACK)) u_pack (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr      (hit_wr),
        .sel     (hit_oh),
        .off     (off),
        .din     (ioctl_dout),
        .flush   (fall),
        .we      (rom_we),
        .addr    (rom_addr),
        .data    (rom_data)
    );
endmodule
